// File: rtl/ulpb_tx_queue.sv
// ulpb_tx_queue: store-and-forward transmit queue driving the bus node TX handshake.
module ulpb_tx_queue #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  WR_EN,
   input  logic [ADDR_WIDTH-1:0] WR_ADDR,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   input  logic                  WR_LAST,
   output logic                  WR_FULL,
   output logic                  WR_ERR,
   output logic                  MSG_DONE,
   output logic                  MSG_FAIL,
   output logic [ADDR_WIDTH-1:0] TX_ADDR,
   output logic [DATA_WIDTH-1:0] TX_DATA,
   output logic                  TX_PEND,
   output logic                  TX_REQ,
   input  logic                  TX_ACK,
   input  logic                  TX_SUCC,
   input  logic                  TX_FAIL,
   output logic                  TX_RESP_ACK
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   typedef enum logic [2:0] {IDLE, REQ, ACK_LOW, WAIT_RESP, RESP, DROP} state_t;
   state_t state, state_nx;
   logic [ADDR_WIDTH+DATA_WIDTH:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0] count, msg_cnt;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic in_msg, head_last, last_r, last_nx, fail_r, fail_nx, pop, wr_ok, ovf;
   assign {head_last, TX_ADDR, TX_DATA} = mem[rptr];
   assign TX_PEND = ~head_last;
   assign WR_FULL = count == FULL_CNT;
   // a full queue with no complete message can never drain, so it is flushed
   assign ovf = WR_FULL && msg_cnt == '0;
   assign wr_ok = WR_EN && (!WR_FULL || pop);
   assign WR_ERR = (WR_EN && !wr_ok) || ovf;
   always_comb begin
      state_nx = state;
      last_nx = last_r;
      fail_nx = fail_r;
      pop = 1'b0;
      TX_REQ = 1'b0;
      TX_RESP_ACK = 1'b0;
      MSG_DONE = 1'b0;
      MSG_FAIL = 1'b0;
      case (state)
         IDLE: begin
            last_nx = 1'b0;
            fail_nx = 1'b0;
            state_nx = msg_cnt != '0 ? REQ : IDLE;
         end
         REQ: begin
            TX_REQ = 1'b1;
            if (TX_ACK) begin
               pop = 1'b1;
               last_nx = head_last;
               state_nx = ACK_LOW;
            end else if (TX_FAIL) begin
               fail_nx = 1'b1;
               state_nx = RESP;
            end
         end
         ACK_LOW: begin
            if (TX_FAIL) begin
               fail_nx = 1'b1;
               state_nx = RESP;
            end else if (!TX_ACK) state_nx = last_r ? WAIT_RESP : REQ;
         end
         WAIT_RESP: begin
            if (TX_SUCC || TX_FAIL) begin
               fail_nx = TX_FAIL;
               state_nx = RESP;
            end
         end
         RESP: begin
            TX_RESP_ACK = 1'b1;
            MSG_DONE = !fail_r;
            MSG_FAIL = fail_r;
            state_nx = fail_r && !last_r ? DROP : IDLE;
         end
         DROP: begin
            pop = count != '0;
            state_nx = pop && head_last ? IDLE : DROP;
         end
         default: state_nx = IDLE;
      endcase
   end
   // continuation words inherit the address of their message's first word
   always_ff @(posedge CLK) begin
      if (wr_ok) mem[wptr] <= {WR_LAST, in_msg ? cur_addr : WR_ADDR, WR_DATA};
      if (wr_ok && !in_msg) cur_addr <= WR_ADDR;
   end
   always_ff @(posedge CLK) begin
      if (RESET || ovf) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
         msg_cnt <= '0;
         in_msg <= 1'b0;
      end else begin
         if (wr_ok) wptr <= wptr + 1'b1;
         if (wr_ok) in_msg <= !WR_LAST;
         if (pop) rptr <= rptr + 1'b1;
         count <= count + (AW+1)'(wr_ok) - (AW+1)'(pop);
         msg_cnt <= msg_cnt + (AW+1)'(wr_ok && WR_LAST) - (AW+1)'(pop && head_last);
      end
      state <= RESET ? IDLE : state_nx;
      last_r <= last_nx;
      fail_r <= fail_nx;
   end
endmodule

// File: tb/tb_ulpb_tx_queue.sv
// tb_ulpb_tx_queue: directed vectors and randomized messages checked against a message-level model.
module tb_ulpb_tx_queue;
   logic CLK = 1'b0, RESET = 1'b1, WR_EN = 1'b0, WR_LAST = 1'b0;
   logic [7:0] WR_ADDR = '0, TX_ADDR;
   logic [31:0] WR_DATA = '0, TX_DATA;
   logic WR_FULL, WR_ERR, MSG_DONE, MSG_FAIL, TX_PEND, TX_REQ, TX_RESP_ACK;
   logic TX_ACK = 1'b0, TX_SUCC = 1'b0, TX_FAIL = 1'b0;
   always #5 CLK = ~CLK;
   ulpb_tx_queue dut (
      .CLK(CLK), .RESET(RESET), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
      .WR_LAST(WR_LAST), .WR_FULL(WR_FULL), .WR_ERR(WR_ERR), .MSG_DONE(MSG_DONE),
      .MSG_FAIL(MSG_FAIL), .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND),
      .TX_REQ(TX_REQ), .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
      .TX_RESP_ACK(TX_RESP_ACK)
   );
   typedef struct {logic [7:0] a; logic [31:0] d; logic p;} word_t;
   typedef struct {int k; bit rs; bit rf;} plan_t;
   typedef struct {logic [7:0] a; logic [31:0] d; bit rs; bit rf; bit done;} vec_t;
   word_t rx_q[$], exp_q[$];
   plan_t plan_q[$], cur;
   int st_q[$], exp_st[$];
   int total = 0, bad = 0, resp_cnt = 0, widx = 0;
   bit req_seen = 0, node_en = 1, last_pend = 0;
   vec_t vt[4];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   // node model: acks each request, injects the planned failure, answers at message end
   always @(negedge CLK) begin
      if (MSG_DONE) st_q.push_back(1);
      if (MSG_FAIL) st_q.push_back(0);
      if (TX_REQ) req_seen = 1;
      if (TX_RESP_ACK) begin
         resp_cnt++;
         TX_SUCC = 0;
         TX_FAIL = 0;
         widx = 0;
      end
      if (node_en && TX_REQ && !TX_ACK) begin
         if (widx == 0) begin
            if (plan_q.size() != 0) cur = plan_q.pop_front();
            else cur = '{0, 1'b1, 1'b0};
         end
         TX_ACK = 1;
         rx_q.push_back('{TX_ADDR, TX_DATA, TX_PEND});
         widx++;
         last_pend = TX_PEND;
         if (widx == cur.k) TX_FAIL = 1;
      end else if (!TX_REQ && TX_ACK) begin
         TX_ACK = 0;
         if (!last_pend && !TX_FAIL) begin
            TX_SUCC = cur.rs;
            TX_FAIL = cur.rf;
         end
      end
   end
   task automatic wr(input logic [7:0] a, input logic [31:0] d, input bit l, output bit err);
      WR_EN = 1;
      WR_ADDR = a;
      WR_DATA = d;
      WR_LAST = l;
      #1 err = WR_ERR;
      @(negedge CLK);
      WR_EN = 0;
   endtask
   task automatic expw(input logic [7:0] a, input logic [31:0] d, input bit p);
      exp_q.push_back('{a, d, p});
   endtask
   task automatic wait_done(input string name);
      for (int i = 0; i < 3000 && st_q.size() < exp_st.size(); i++) @(negedge CLK);
      repeat (4) @(negedge CLK);
      chk({name, "_nwords"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         chk({name, "_addr"}, rx_q[i].a, exp_q[i].a);
         chk({name, "_data"}, rx_q[i].d, exp_q[i].d);
         chk({name, "_pend"}, rx_q[i].p, exp_q[i].p);
      end
      chk({name, "_nstat"}, st_q.size(), exp_st.size());
      for (int i = 0; i < st_q.size() && i < exp_st.size(); i++)
         chk({name, "_status"}, st_q[i], exp_st[i]);
      rx_q.delete();
      exp_q.delete();
      st_q.delete();
      exp_st.delete();
   endtask
   initial begin
      bit e;
      int r0;
      vt[0] = '{8'h5A, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1};
      vt[1] = '{8'h00, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vt[2] = '{8'hFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
      vt[3] = '{8'h3C, 32'h12345678, 1'b1, 1'b1, 1'b0};
      repeat (2) @(negedge CLK);
      RESET = 0;
      chk("reset_outs", {TX_REQ, TX_RESP_ACK, MSG_DONE, MSG_FAIL, WR_ERR, WR_FULL}, 0);
      for (int v = 0; v < 4; v++) begin
         plan_q.push_back('{0, vt[v].rs, vt[v].rf});
         expw(vt[v].a, vt[v].d, 0);
         exp_st.push_back(vt[v].done);
         r0 = resp_cnt;
         wr(vt[v].a, vt[v].d, 1, e);
         chk("vec_wr_err", e, 0);
         chk("vec_req_lat0", TX_REQ, 0);
         @(negedge CLK);
         chk("vec_req_lat1", TX_REQ, 1);
         wait_done("vec");
         chk("vec_resp_ack", resp_cnt - r0, 1);
         chk("vec_full", WR_FULL, 0);
      end
      req_seen = 0;
      wr(8'h77, 1, 0, e);
      repeat (5) @(negedge CLK);
      wr(8'h88, 2, 0, e);
      repeat (5) @(negedge CLK);
      wr(8'h99, 3, 1, e);
      chk("gap_no_early_req", req_seen, 0);
      expw(8'h77, 1, 1);
      expw(8'h77, 2, 1);
      expw(8'h77, 3, 0);
      exp_st.push_back(1);
      wait_done("gap");
      node_en = 0;
      for (int w = 0; w < 8; w++) begin
         wr(w < 4 ? 8'hA0 : 8'hB0, 32'(w), w == 3 || w == 7, e);
         chk("fill_wr_err", e, 0);
         expw(w < 4 ? 8'hA0 : 8'hB0, 32'(w), !(w == 3 || w == 7));
      end
      chk("fill_full", WR_FULL, 1);
      wr(8'hC0, 32'hBAD, 1, e);
      chk("fill_9th_err", e, 1);
      chk("fill_still_full", WR_FULL, 1);
      exp_st.push_back(1);
      exp_st.push_back(1);
      node_en = 1;
      wait_done("fill");
      chk("fill_empty", WR_FULL, 0);
      req_seen = 0;
      repeat (10) @(negedge CLK);
      chk("fill_no_extra_req", req_seen, 0);
      plan_q.push_back('{1, 1'b1, 1'b0});
      for (int w = 0; w < 3; w++) wr(8'h31, 32'h31 + 32'(w), w == 2, e);
      wr(8'h42, 32'h42, 1, e);
      expw(8'h31, 32'h31, 1);
      expw(8'h42, 32'h42, 0);
      exp_st.push_back(0);
      exp_st.push_back(1);
      wait_done("fail");
      req_seen = 0;
      for (int w = 0; w < 8; w++) begin
         wr(8'h66, 32'(w), 0, e);
         if (w < 7) chk("ovf_wr_err", e, 0);
      end
      chk("ovf_err_pulse", WR_ERR, 1);
      @(negedge CLK);
      chk("ovf_err_clear", WR_ERR, 0);
      chk("ovf_flushed", WR_FULL, 0);
      repeat (10) @(negedge CLK);
      chk("ovf_no_req", req_seen, 0);
      wr(8'h67, 32'h67, 1, e);
      expw(8'h67, 32'h67, 0);
      exp_st.push_back(1);
      wait_done("ovf_after");
      wr(8'h55, 1, 0, e);
      wr(8'h55, 2, 1, e);
      for (int i = 0; i < 200 && !(rx_q.size() == 1 && !TX_REQ); i++) @(negedge CLK);
      chk("rst_reached_ack_low", rx_q.size(), 1);
      RESET = 1;
      @(negedge CLK);
      RESET = 0;
      widx = 0;
      chk("rst_mid_outs", {TX_REQ, TX_RESP_ACK, MSG_DONE, MSG_FAIL, WR_ERR, WR_FULL}, 0);
      req_seen = 0;
      repeat (20) @(negedge CLK);
      chk("rst_no_status", st_q.size(), 0);
      chk("rst_no_req", req_seen, 0);
      rx_q.delete();
      wr(8'h56, 32'h56, 1, e);
      expw(8'h56, 32'h56, 0);
      exp_st.push_back(1);
      wait_done("rst_after");
      for (int m = 0; m < 30; m++) begin
         int len;
         plan_t p;
         logic [7:0] a0;
         logic [31:0] d;
         len = $urandom_range(1, 4);
         p.k = $urandom_range(0, 5);
         if (p.k > len) p.k = 0;
         p.rs = 1;
         p.rf = $urandom_range(0, 3) == 0;
         a0 = 8'($urandom);
         plan_q.push_back(p);
         exp_st.push_back(p.k != 0 || p.rf ? 0 : 1);
         for (int w = 0; w < len; w++) begin
            d = $urandom;
            if (p.k == 0 || w < p.k) expw(a0, d, w != len - 1);
            for (int t = 0; t < 100 && WR_FULL; t++) @(negedge CLK);
            wr(w == 0 ? a0 : 8'($urandom), d, w == len - 1, e);
            chk("rand_wr_err", e, 0);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
         end
      end
      wait_done("rand");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
